// File: rtl/cpu_design_params.sv
// Core-wide sizing constants and shared rename types.
// Free-list geometry lives here so rename, retire and the allocator agree on widths.
package cpu_design_params;

    localparam int NUM_P_REGS    = 48;
    localparam int NUM_A_REGS    = 32;
    localparam int PRN_WIDTH     = $clog2(NUM_P_REGS);
    localparam int MAX_FREE_REGS = 16;
    localparam int F_LIST_WDTH   = $clog2(MAX_FREE_REGS);

    typedef logic [PRN_WIDTH-1:0] prn_t;

    // Wrap bit on top of the list index, so full and empty are distinguishable.
    typedef logic [F_LIST_WDTH:0] fl_ptr_t;

endpackage

// File: rtl/phys_reg_allocator_pkg.sv
// Free-list helpers shared by the allocator and its interface.
// Pointer arithmetic is kept here so the wrap-bit behaviour is defined in exactly one place.
package phys_reg_allocator_pkg;

    import cpu_design_params::*;

    typedef logic [F_LIST_WDTH:0] fl_cnt_t;

    localparam fl_cnt_t FULL_COUNT = fl_cnt_t'(MAX_FREE_REGS);

    function automatic logic [F_LIST_WDTH-1:0] ptr_idx(input fl_ptr_t p);
        return p[F_LIST_WDTH-1:0];
    endfunction

    // Carry out of the index field lands in the wrap bit.
    function automatic fl_ptr_t ptr_inc(input fl_ptr_t p, input logic en);
        return p + fl_ptr_t'(en);
    endfunction

endpackage

// File: rtl/phys_reg_allocator_if.sv
// Rename/retire side bundle of the physical register free list.
// err is present only when PHYS_ALLOC_CHECK_EN is defined.
interface phys_reg_allocator_if;

    import cpu_design_params::*;

    logic                 alloc_req;
    logic                 alloc_gnt;
    prn_t                 alloc_prn;
    logic                 commit_valid;
    logic                 free_valid;
    prn_t                 free_prn;
    logic                 flush;
    logic [F_LIST_WDTH:0] free_count;
    logic                 empty;
`ifdef PHYS_ALLOC_CHECK_EN
    logic                 err;
`endif

`ifdef PHYS_ALLOC_CHECK_EN
    modport master (
        output alloc_req, commit_valid, free_valid, free_prn, flush,
        input  alloc_gnt, alloc_prn, free_count, empty, err
    );

    modport slave (
        input  alloc_req, commit_valid, free_valid, free_prn, flush,
        output alloc_gnt, alloc_prn, free_count, empty, err
    );
`else
    modport master (
        output alloc_req, commit_valid, free_valid, free_prn, flush,
        input  alloc_gnt, alloc_prn, free_count, empty
    );

    modport slave (
        input  alloc_req, commit_valid, free_valid, free_prn, flush,
        output alloc_gnt, alloc_prn, free_count, empty
    );
`endif

endinterface

// File: rtl/phys_reg_allocator.sv
// Physical register free list: circular list of spare PRNs with speculative head, committed head and tail.
// Latency: alloc_gnt/alloc_prn combinational from alloc_req; free_count/empty registered, updated at the next edge.
// Backpressure: alloc_gnt drops while the registered count is zero or flush is high; macro PHYS_ALLOC_CHECK_EN adds sticky err.
module phys_reg_allocator #(
    parameter int NUM_P_REGS = cpu_design_params::NUM_P_REGS,
    parameter int NUM_A_REGS = cpu_design_params::NUM_A_REGS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    phys_reg_allocator_if.slave  bus
);

    import cpu_design_params::prn_t;
    import cpu_design_params::fl_ptr_t;
    import cpu_design_params::MAX_FREE_REGS;
    import phys_reg_allocator_pkg::*;

    // Spare registers beyond the identity-mapped architectural set seed the list.
    localparam int NUM_SPARE = NUM_P_REGS - NUM_A_REGS;

    prn_t    list_q [MAX_FREE_REGS];
    fl_ptr_t spec_head_q;
    fl_ptr_t commit_head_q;
    fl_ptr_t tail_q;
    fl_cnt_t count_q;

    logic    empty;
    logic    alloc_gnt;
    logic    free_ovf;
    logic    commit_ovf;
    logic    do_free;
    logic    do_commit;
    fl_ptr_t spec_head_d;
    fl_ptr_t commit_head_d;
    fl_ptr_t tail_d;
    fl_cnt_t count_d;

    always_comb begin
        empty      = (count_q == '0);
        // Grant decision uses only the registered count; a same-cycle free is not bypassed.
        alloc_gnt  = rst_n && bus.alloc_req && !empty && !bus.flush;

        free_ovf   = bus.free_valid   && (count_q == FULL_COUNT);
        commit_ovf = bus.commit_valid && (commit_head_q == spec_head_q);
        do_free    = bus.free_valid   && !free_ovf;
        do_commit  = bus.commit_valid && !commit_ovf;

        commit_head_d = ptr_inc(commit_head_q, do_commit);
        tail_d        = ptr_inc(tail_q, do_free);
        // A flush rewinds speculation to the committed point, including a commit retiring this cycle.
        spec_head_d   = bus.flush ? commit_head_d : ptr_inc(spec_head_q, alloc_gnt);
        count_d       = fl_cnt_t'(tail_d - spec_head_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_FREE_REGS; i++) begin
                list_q[i] <= prn_t'(NUM_A_REGS + i);
            end
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= fl_ptr_t'(NUM_SPARE);
            count_q       <= fl_cnt_t'(NUM_SPARE);
        end else begin
            if (do_free) begin
                list_q[ptr_idx(tail_q)] <= bus.free_prn;
            end
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    assign bus.alloc_gnt  = alloc_gnt;
    assign bus.alloc_prn  = list_q[ptr_idx(spec_head_q)];
    assign bus.free_count = count_q;
    assign bus.empty      = empty;

`ifdef PHYS_ALLOC_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (free_ovf || commit_ovf || (bus.alloc_req && empty && !bus.flush)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_phys_reg_allocator.sv
// Directed self-checking bench for phys_reg_allocator; err checks compile in with PHYS_ALLOC_CHECK_EN.
module tb_phys_reg_allocator;

    import cpu_design_params::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    phys_reg_allocator_if bus_if ();

    phys_reg_allocator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        bus_if.alloc_req    = 1'b0;
        bus_if.commit_valid = 1'b0;
        bus_if.free_valid   = 1'b0;
        bus_if.free_prn     = '0;
        bus_if.flush        = 1'b0;
    endtask

    // Leaves the bench 1 ns after a clock edge with inputs idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    // Reset is held with every request input active to show it dominates them.
    task automatic apply_reset();
        rst_n               = 1'b0;
        bus_if.alloc_req    = 1'b1;
        bus_if.flush        = 1'b1;
        bus_if.commit_valid = 1'b1;
        bus_if.free_valid   = 1'b1;
        bus_if.free_prn     = 6'd3;
        repeat (2) @(posedge clk);
        #1;
        drive_idle();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n               = 1'b0;
        bus_if.alloc_req    = 1'b1;
        bus_if.flush        = 1'b0;
        bus_if.commit_valid = 1'b1;
        bus_if.free_valid   = 1'b1;
        bus_if.free_prn     = 6'd3;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus_if.alloc_gnt !== 1'b0) $display("FAIL reset_gnt: got %b want 0", bus_if.alloc_gnt);
        else n_pass++;
        n_checks++;
        if (bus_if.free_count !== 5'd16) $display("FAIL reset_count: got %0d want 16", bus_if.free_count);
        else n_pass++;
        n_checks++;
        if (bus_if.empty !== 1'b0) $display("FAIL reset_empty: got %b want 0", bus_if.empty);
        else n_pass++;
        n_checks++;
        if (bus_if.alloc_prn !== 6'd32) $display("FAIL reset_prn: got %0d want 32", bus_if.alloc_prn);
        else n_pass++;
`ifdef PHYS_ALLOC_CHECK_EN
        n_checks++;
        if (bus_if.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus_if.err);
        else n_pass++;
`endif
        drive_idle();
        rst_n = 1'b1;
        next_cycle();
        n_checks++;
        if (bus_if.free_count !== 5'd16) $display("FAIL reset_idle_count: got %0d want 16", bus_if.free_count);
        else n_pass++;
    endtask

    // Drains the list from reset; leaves it empty.
    task automatic test_alloc_all();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            bus_if.alloc_req = 1'b1;
            #1;
            n_checks++;
            if (bus_if.alloc_gnt !== 1'b1 || bus_if.alloc_prn !== 6'(32 + i))
                $display("FAIL alloc_all[%0d]: got gnt=%b prn=%0d want gnt=1 prn=%0d",
                         i, bus_if.alloc_gnt, bus_if.alloc_prn, 32 + i);
            else n_pass++;
            next_cycle();
        end
        bus_if.alloc_req = 1'b1;
        #1;
        n_checks++;
        if (bus_if.alloc_gnt !== 1'b0 || bus_if.empty !== 1'b1 || bus_if.free_count !== 5'd0)
            $display("FAIL alloc_17th: got gnt=%b empty=%b count=%0d want 0 1 0",
                     bus_if.alloc_gnt, bus_if.empty, bus_if.free_count);
        else n_pass++;
        drive_idle();
    endtask

    // Continues from an empty list: a free is not visible to a grant in the same cycle.
    task automatic test_free_alloc_same_cycle();
        bus_if.free_valid = 1'b1;
        bus_if.free_prn   = 6'd5;
        bus_if.alloc_req  = 1'b1;
        #1;
        n_checks++;
        if (bus_if.alloc_gnt !== 1'b0) $display("FAIL same_cycle_gnt: got %b want 0", bus_if.alloc_gnt);
        else n_pass++;
        next_cycle();
        n_checks++;
        if (bus_if.free_count !== 5'd1) $display("FAIL same_cycle_count: got %0d want 1", bus_if.free_count);
        else n_pass++;
        bus_if.alloc_req = 1'b1;
        #1;
        n_checks++;
        if (bus_if.alloc_gnt !== 1'b1 || bus_if.alloc_prn !== 6'd5)
            $display("FAIL freed_grant: got gnt=%b prn=%0d want gnt=1 prn=5", bus_if.alloc_gnt, bus_if.alloc_prn);
        else n_pass++;
        next_cycle();
        n_checks++;
        if (bus_if.free_count !== 5'd0 || bus_if.empty !== 1'b1)
            $display("FAIL freed_drain: got count=%0d empty=%b want 0 1", bus_if.free_count, bus_if.empty);
        else n_pass++;
    endtask

    // Four allocations, one commit, then flush: three speculative PRNs return.
    task automatic test_flush();
        apply_reset();
        repeat (4) begin
            bus_if.alloc_req = 1'b1;
            next_cycle();
        end
        bus_if.commit_valid = 1'b1;
        next_cycle();
        bus_if.flush     = 1'b1;
        bus_if.alloc_req = 1'b1;
        #1;
        n_checks++;
        if (bus_if.alloc_gnt !== 1'b0) $display("FAIL flush_blocks_gnt: got %b want 0", bus_if.alloc_gnt);
        else n_pass++;
        next_cycle();
        n_checks++;
        if (bus_if.free_count !== 5'd15) $display("FAIL flush_count: got %0d want 15", bus_if.free_count);
        else n_pass++;
        bus_if.alloc_req = 1'b1;
        #1;
        n_checks++;
        if (bus_if.alloc_gnt !== 1'b1 || bus_if.alloc_prn !== 6'd33)
            $display("FAIL flush_next_prn: got gnt=%b prn=%0d want gnt=1 prn=33", bus_if.alloc_gnt, bus_if.alloc_prn);
        else n_pass++;
        next_cycle();
        n_checks++;
        if (bus_if.free_count !== 5'd14) $display("FAIL flush_regrant_count: got %0d want 14", bus_if.free_count);
        else n_pass++;
    endtask

    // Three allocations, one prior commit (commit_head=1), then flush+commit: spec_head becomes 2.
    task automatic test_flush_with_commit();
        apply_reset();
        repeat (3) begin
            bus_if.alloc_req = 1'b1;
            next_cycle();
        end
        bus_if.commit_valid = 1'b1;
        next_cycle();
        bus_if.commit_valid = 1'b1;
        bus_if.flush        = 1'b1;
        next_cycle();
        n_checks++;
        if (bus_if.free_count !== 5'd14) $display("FAIL flush_commit_count: got %0d want 14", bus_if.free_count);
        else n_pass++;
        bus_if.alloc_req = 1'b1;
        #1;
        n_checks++;
        if (bus_if.alloc_prn !== 6'd34) $display("FAIL flush_commit_prn: got %0d want 34", bus_if.alloc_prn);
        else n_pass++;
        drive_idle();
    endtask

    // Flush and a legal free in the same cycle: both take effect.
    task automatic test_flush_free();
        apply_reset();
        repeat (2) begin
            bus_if.alloc_req = 1'b1;
            next_cycle();
        end
        bus_if.commit_valid = 1'b1;
        next_cycle();
        bus_if.flush      = 1'b1;
        bus_if.free_valid = 1'b1;
        bus_if.free_prn   = 6'd32;
        next_cycle();
        n_checks++;
        if (bus_if.free_count !== 5'd16) $display("FAIL flush_free_count: got %0d want 16", bus_if.free_count);
        else n_pass++;
        n_checks++;
        if (bus_if.alloc_prn !== 6'd33) $display("FAIL flush_free_prn: got %0d want 33", bus_if.alloc_prn);
        else n_pass++;
    endtask

    // Commit with nothing allocated must not move commit_head; a flush afterwards exposes it.
    task automatic test_illegal_commit();
        apply_reset();
        bus_if.commit_valid = 1'b1;
        next_cycle();
        bus_if.flush = 1'b1;
        next_cycle();
        n_checks++;
        if (bus_if.free_count !== 5'd16 || bus_if.alloc_prn !== 6'd32)
            $display("FAIL illegal_commit: got count=%0d prn=%0d want 16 32", bus_if.free_count, bus_if.alloc_prn);
        else n_pass++;
`ifdef PHYS_ALLOC_CHECK_EN
        n_checks++;
        if (bus_if.err !== 1'b1) $display("FAIL illegal_commit_err: got %b want 1", bus_if.err);
        else n_pass++;
`endif
    endtask

    // Free into a full list is dropped: tail and contents stay put.
    task automatic test_illegal_free();
        apply_reset();
`ifdef PHYS_ALLOC_CHECK_EN
        n_checks++;
        if (bus_if.err !== 1'b0) $display("FAIL err_clear: got %b want 0", bus_if.err);
        else n_pass++;
`endif
        bus_if.free_valid = 1'b1;
        bus_if.free_prn   = 6'd9;
        next_cycle();
        n_checks++;
        if (bus_if.free_count !== 5'd16) $display("FAIL over_free_count: got %0d want 16", bus_if.free_count);
        else n_pass++;
`ifdef PHYS_ALLOC_CHECK_EN
        n_checks++;
        if (bus_if.err !== 1'b1) $display("FAIL over_free_err: got %b want 1", bus_if.err);
        else n_pass++;
`endif
        for (int i = 0; i < 16; i++) begin
            bus_if.alloc_req = 1'b1;
            #1;
            n_checks++;
            if (bus_if.alloc_gnt !== 1'b1 || bus_if.alloc_prn !== 6'(32 + i))
                $display("FAIL over_free_list[%0d]: got gnt=%b prn=%0d want gnt=1 prn=%0d",
                         i, bus_if.alloc_gnt, bus_if.alloc_prn, 32 + i);
            else n_pass++;
            next_cycle();
        end
        n_checks++;
        if (bus_if.empty !== 1'b1) $display("FAIL over_free_empty: got %b want 1", bus_if.empty);
        else n_pass++;
`ifdef PHYS_ALLOC_CHECK_EN
        n_checks++;
        if (bus_if.err !== 1'b1) $display("FAIL err_sticky: got %b want 1", bus_if.err);
        else n_pass++;
        apply_reset();
        n_checks++;
        if (bus_if.err !== 1'b0) $display("FAIL err_reset: got %b want 0", bus_if.err);
        else n_pass++;
`endif
    endtask

    // 40 allocations with commits and frees of earlier grants, then a drain, crossing the wrap twice.
    task automatic test_wrap();
        prn_t expect_q[$];
        prn_t owned_q[$];
        prn_t freed;
        int   pending;
        apply_reset();
        for (int i = 0; i < 16; i++) expect_q.push_back(prn_t'(32 + i));
        pending = 0;
        freed   = '0;
        for (int cyc = 0; cyc < 44; cyc++) begin
            bus_if.alloc_req    = (cyc < 40);
            bus_if.commit_valid = (pending > 0);
            bus_if.free_valid   = (owned_q.size() >= 4) || (cyc >= 40 && owned_q.size() > 0);
            if (bus_if.free_valid) begin
                freed           = owned_q.pop_front();
                bus_if.free_prn = freed;
            end
            #1;
            if (bus_if.alloc_req) begin
                n_checks++;
                if (bus_if.alloc_gnt !== 1'b1 || bus_if.alloc_prn !== expect_q[0])
                    $display("FAIL wrap_grant[%0d]: got gnt=%b prn=%0d want gnt=1 prn=%0d",
                             cyc, bus_if.alloc_gnt, bus_if.alloc_prn, expect_q[0]);
                else n_pass++;
                owned_q.push_back(expect_q.pop_front());
                pending++;
            end
            if (bus_if.free_valid) expect_q.push_back(freed);
            if (bus_if.commit_valid) pending--;
            next_cycle();
            n_checks++;
            if (bus_if.free_count !== 5'(expect_q.size()))
                $display("FAIL wrap_count[%0d]: got %0d want %0d", cyc, bus_if.free_count, expect_q.size());
            else n_pass++;
        end
        n_checks++;
        if (bus_if.free_count !== 5'd16) $display("FAIL wrap_final_count: got %0d want 16", bus_if.free_count);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        drive_idle();
        test_reset();
        test_alloc_all();
        test_free_alloc_same_cycle();
        test_reset();
        test_flush();
        test_flush_with_commit();
        test_flush_free();
        test_illegal_commit();
        test_illegal_free();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
